seven_seg_capture: RTL and testbench
====================================

Name: seven_seg_capture

Overview:
Decoder for the multiplexed seven-segment display bus (seg/an) that the score display drives. It watches the scanned anode and segment lines, waits for each scan slot to settle, and decodes the segment pattern back to a 4-bit digit. It assembles a full four-digit frame and presents it atomically with a strobe. It is used as an on-chip monitor and by the verification bench to read back the displayed score without visual inspection.

Parameters:
SETTLE_CYCLES, 16, consecutive cycles an/seg must be unchanged before a slot is sampled (range 1..65535)
TIMEOUT_CYCLES, 1048576, cycles with no successful sample before timeout is flagged (range 2..2^24)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
seg  input  8  segment lines, active-low; seg[0]=a … seg[6]=g, seg[7]=dp
an  input  4  anode enables, active-low; an[3]=digit_1 (leftmost, thousands) … an[0]=digit_4 (ones)
digit_1  output  4  captured thousands digit (0-9; 4'hF = blank)
digit_2  output  4  captured hundreds digit
digit_3  output  4  captured tens digit
digit_4  output  4  captured ones digit
blank  output  4  per-digit blank flag, bit order as an
frame_valid  output  1  one-cycle pulse when digit_1..4/blank update
decode_err  output  1  one-cycle pulse when a settled slot holds an illegal pattern
timeout  output  1  level; high while no sample has occurred for TIMEOUT_CYCLES

Behaviour:
- Reset (clk edge with rst=1): digit_1..4=4'hF, blank=4'b1111, frame_valid=0, decode_err=0, timeout=0, captured mask=0, settle counter=0, timeout counter=0, FSM=WAIT.
- Inputs are registered twice before use; all latencies below count from the second register stage.
- FSM states: WAIT (counting settle), HELD (slot already sampled, waiting for change).
- WAIT: if {an,seg} equals the previous cycle's value, increment the settle counter; otherwise clear it. When the counter reaches SETTLE_CYCLES-1 with equal input, evaluate the slot and go to HELD.
- HELD: any change in {an,seg} clears the settle counter and goes to WAIT. A slot is sampled at most once per steady interval.
- Slot evaluation: an must have exactly one bit low. an=4'b1111 (all off, e.g. blink phase) or multiple bits low: no sample, no error, go to HELD.
- Decode of seg[6:0] (dp ignored): 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10→9, 0x7F→blank (code 4'hF, blank bit=1). Any other pattern: pulse decode_err; the slot is not captured.
- A valid sample writes a shadow register for that position, sets its captured-mask bit, and clears the timeout counter and timeout.
- Frame: on the cycle after the captured mask becomes 4'b1111, copy the shadows to digit_1..4/blank, pulse frame_valid for one cycle, and clear the mask. Outputs hold between frames.
- A position re-sampled before the frame completes overwrites its shadow (latest value wins).
- The timeout counter increments on every cycle without a valid sample and saturates. At TIMEOUT_CYCLES it sets timeout=1 and clears the captured mask. Outputs keep their last frame.
- Simultaneous valid sample and frame completion: frame copy uses the pre-write shadows. The new sample goes to the next frame.
- rst mid-frame discards the partial frame and all shadows.

Test Plan:
- Drive an scan 0111→1011→1101→1110, each slot 100 cycles, with seg patterns 0x79, 0x24, 0x30, 0x19 → one frame_valid; digit_1..4=1,2,3,4; blank=0000.
- Score 7 display (slots 1-3 seg=0x7F, ones seg=0x78) → digit_1..3=F, digit_4=7, blank=1110.
- Slot held only SETTLE_CYCLES-2 cycles, then changed → no sample, no frame_valid; a glitch mid-slot restarts the settle count.
- Settled slot with seg=0x55 → single decode_err pulse, mask bit unchanged, no frame.
- an=1111 for TIMEOUT_CYCLES (use TIMEOUT_CYCLES=64 in sim) → timeout=1 at cycle 64, digits unchanged; the next valid sample drops timeout.
- Assert rst after 3 of 4 slots captured, then scan 9,8,0,6 → the single frame_valid shows 9,8,0,6, with no mix of pre-reset data.

Source files
------------

// File: rtl/seven_seg_capture_if.sv
// Multiplexed seven-segment display bus: active-low segment and anode lines.
interface seven_seg_capture_if;
    logic [7:0] seg;
    logic [3:0] an;

    modport master (output seg, output an);
    modport slave  (input seg, input an);
endinterface

// File: rtl/seven_seg_capture.sv
// Watches a scanned seven-segment bus, samples each settled slot once,
// decodes it back to a digit and publishes complete four-digit frames.
module seven_seg_capture #(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic                clk,
    input  logic                rst,
    seven_seg_capture_if.slave  bus,
    output logic [3:0]          digit_1,
    output logic [3:0]          digit_2,
    output logic [3:0]          digit_3,
    output logic [3:0]          digit_4,
    output logic [3:0]          blank,
    output logic                frame_valid,
    output logic                decode_err,
    output logic                timeout
);

    localparam int unsigned TW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] T_MAX     = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_REACH   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        WAIT,
        HELD
    } state_t;

    state_t        state;
    logic [11:0]   sync1, sync2, prev;
    logic [15:0]   settle;
    logic [TW-1:0] tcnt;
    logic [3:0]    mask;
    logic [3:0]    mask_next;
    logic [3:0]    shadow [4];
    logic [3:0]    shadow_blank;

    logic          same;
    logic          eval_now;
    logic          one_hot;
    logic [1:0]    pos;
    logic [3:0]    code;
    logic          is_blank;
    logic          legal;
    logic          sample_ok;
    logic          frame_ready;

    // Two-stage input register plus one delayed copy for change detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
        end else begin
            sync1 <= {bus.an, bus.seg};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Slot decode: anode position, segment pattern and sample qualification.
    always_comb begin
        code     = 4'hF;
        is_blank = 1'b0;
        legal    = 1'b1;
        unique case (sync2[6:0])
            7'h40:   code = 4'd0;
            7'h79:   code = 4'd1;
            7'h24:   code = 4'd2;
            7'h30:   code = 4'd3;
            7'h19:   code = 4'd4;
            7'h12:   code = 4'd5;
            7'h02:   code = 4'd6;
            7'h78:   code = 4'd7;
            7'h00:   code = 4'd8;
            7'h10:   code = 4'd9;
            7'h7F:   is_blank = 1'b1;
            default: legal = 1'b0;
        endcase

        one_hot = 1'b1;
        pos     = 2'd0;
        unique case (sync2[11:8])
            4'b0111: pos = 2'd3;
            4'b1011: pos = 2'd2;
            4'b1101: pos = 2'd1;
            4'b1110: pos = 2'd0;
            default: one_hot = 1'b0;
        endcase

        same        = (sync2 == prev);
        eval_now    = (state == WAIT) && same && (settle == SETTLE_LAST);
        sample_ok   = eval_now && one_hot && legal;
        frame_ready = (mask == 4'hF);
        // A sample landing on the frame-copy cycle starts the next frame.
        mask_next   = (frame_ready ? 4'h0 : mask) |
                      (sample_ok ? (4'b0001 << pos) : 4'h0);
    end

    // Settle FSM, shadow capture, frame publication and timeout tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= WAIT;
            settle       <= '0;
            tcnt         <= '0;
            timeout      <= 1'b0;
            mask         <= '0;
            shadow_blank <= '1;
            for (int unsigned i = 0; i < 4; i++) begin
                shadow[i] <= 4'hF;
            end
            digit_1      <= 4'hF;
            digit_2      <= 4'hF;
            digit_3      <= 4'hF;
            digit_4      <= 4'hF;
            blank        <= '1;
            frame_valid  <= 1'b0;
            decode_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            decode_err  <= eval_now && one_hot && !legal;

            unique case (state)
                WAIT: begin
                    if (!same) begin
                        settle <= '0;
                    end else if (settle == SETTLE_LAST) begin
                        state <= HELD;
                    end else begin
                        settle <= settle + 16'd1;
                    end
                end
                HELD: begin
                    if (!same) begin
                        settle <= '0;
                        state  <= WAIT;
                    end
                end
                default: state <= WAIT;
            endcase

            if (sample_ok) begin
                shadow[pos]       <= code;
                shadow_blank[pos] <= is_blank;
            end

            if (frame_ready) begin
                digit_1     <= shadow[3];
                digit_2     <= shadow[2];
                digit_3     <= shadow[1];
                digit_4     <= shadow[0];
                blank       <= shadow_blank;
                frame_valid <= 1'b1;
            end

            mask <= mask_next;

            if (sample_ok) begin
                tcnt    <= '0;
                timeout <= 1'b0;
            end else if (tcnt != T_MAX) begin
                tcnt <= tcnt + 1'b1;
                if (tcnt == T_REACH) begin
                    timeout <= 1'b1;
                    mask    <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: directed scenarios plus a randomized scan,
// checked against a slot-level reference model.
module tb_seven_seg_capture;

    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 64;
    localparam int SLOT    = 40;

    logic       clk;
    logic       rst;
    logic [3:0] digit_1, digit_2, digit_3, digit_4, blank;
    logic       frame_valid, decode_err, timeout;

    seven_seg_capture_if bus_if ();

    seven_seg_capture #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if),
        .digit_1     (digit_1),
        .digit_2     (digit_2),
        .digit_3     (digit_3),
        .digit_4     (digit_4),
        .blank       (blank),
        .frame_valid (frame_valid),
        .decode_err  (decode_err),
        .timeout     (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed frames and decode errors.
    logic [19:0] got_q [$];
    int          err_cnt = 0;
    always @(negedge clk) begin
        if (frame_valid) got_q.push_back({digit_1, digit_2, digit_3, digit_4, blank});
        if (decode_err) err_cnt++;
    end

    // Reference model state.
    logic [6:0]  seg_tab [11] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                  7'h02, 7'h78, 7'h00, 7'h10, 7'h7F};
    logic [3:0]  m_dig [4];
    logic [3:0]  m_blank;
    logic [3:0]  m_mask;
    int          last_t;
    int          exp_err = 0;
    logic [19:0] exp_q [$];
    logic [19:0] last_frame = 20'hFFFFF;
    logic [11:0] last_applied = 12'hFFF;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_dig[i] = 4'hF;
        m_blank = 4'hF;
        m_mask  = 4'h0;
        last_t  = cyc;
        last_frame = 20'hFFFFF;
    endtask

    // Put a slot on the bus and update the model: a one-hot slot stable for
    // more than SETTLE cycles is sampled 3+SETTLE edges after it is applied.
    task automatic apply_slot(input logic [3:0] a, input logic [7:0] s, input int len);
        int pos;
        int code;
        int t;
        bus_if.an    = a;
        bus_if.seg   = s;
        last_applied = {a, s};
        pos = -1;
        case (a)
            4'b0111: pos = 3;
            4'b1011: pos = 2;
            4'b1101: pos = 1;
            4'b1110: pos = 0;
            default: pos = -1;
        endcase
        if (pos >= 0 && len >= SETTLE + 1) begin
            code = -1;
            for (int k = 0; k < 11; k++) if (seg_tab[k] == s[6:0]) code = k;
            if (code < 0) begin
                exp_err++;
            end else begin
                t = cyc + 3 + SETTLE;
                if (t - last_t > TIMEOUT) m_mask = 4'h0;
                last_t = t;
                m_dig[pos]   = (code == 10) ? 4'hF : 4'(code);
                m_blank[pos] = (code == 10);
                m_mask[pos]  = 1'b1;
                if (m_mask == 4'hF) begin
                    last_frame = {m_dig[3], m_dig[2], m_dig[1], m_dig[0], m_blank};
                    exp_q.push_back(last_frame);
                    m_mask = 4'h0;
                end
            end
        end
    endtask

    task automatic drive_slot(input logic [3:0] a, input logic [7:0] s, input int len);
        apply_slot(a, s, len);
        repeat (len) @(posedge clk);
        #1;
    endtask

    task automatic digit_slot(input int pos, input int v, input int len);
        logic [3:0] a;
        logic [7:0] s;
        a = 4'hF;
        a[pos] = 1'b0;
        s = {1'b1, seg_tab[v]};
        drive_slot(a, s, len);
    endtask

    task automatic check_frames(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_frame"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
        check({tag, "_errs"}, err_cnt, exp_err);
    endtask

    task automatic do_reset();
        bus_if.an  = 4'hF;
        bus_if.seg = 8'hFF;
        last_applied = 12'hFFF;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int st;
        logic [3:0] a;
        logic [7:0] s;
        int r;

        rst        = 1'b1;
        bus_if.an  = 4'hF;
        bus_if.seg = 8'hFF;
        @(posedge clk);
        do_reset();

        // Reset state.
        check("rst_digits", {digit_1, digit_2, digit_3, digit_4}, 16'hFFFF);
        check("rst_blank", blank, 4'hF);
        check("rst_fv", frame_valid, 1'b0);
        check("rst_err", decode_err, 1'b0);
        check("rst_timeout", timeout, 1'b0);

        // Display 1234.
        drive_slot(4'b0111, 8'hF9, SLOT);
        drive_slot(4'b1011, 8'hA4, SLOT);
        drive_slot(4'b1101, 8'hB0, SLOT);
        drive_slot(4'b1110, 8'h99, SLOT);
        check_frames("f1234");
        check("f1234_out", {digit_1, digit_2, digit_3, digit_4, blank}, 20'h12340);

        // Score 7 with leading blanks.
        drive_slot(4'b0111, 8'hFF, SLOT);
        drive_slot(4'b1011, 8'hFF, SLOT);
        drive_slot(4'b1101, 8'hFF, SLOT);
        drive_slot(4'b1110, 8'hF8, SLOT);
        check_frames("score7");
        check("score7_out", {digit_1, digit_2, digit_3, digit_4, blank}, 20'hFFF7E);

        // Slots too short to settle, a mid-slot glitch and the settle boundary.
        digit_slot(3, 5, SETTLE - 2);
        digit_slot(2, 6, 8);
        drive_slot(4'b1011, 8'h13, 1);
        digit_slot(2, 6, 8);
        digit_slot(1, 8, SETTLE);
        digit_slot(0, 9, SLOT);
        check_frames("short");
        digit_slot(3, 2, SETTLE + 1);
        digit_slot(2, 0, SETTLE + 1);
        digit_slot(1, 3, SLOT);
        check_frames("boundary");

        // Illegal pattern on a settled slot.
        drive_slot(4'b0111, 8'h55, SLOT);
        digit_slot(2, 4, SLOT);
        digit_slot(1, 4, SLOT);
        digit_slot(0, 4, SLOT);
        check_frames("illegal");
        digit_slot(3, 7, SLOT);
        check_frames("illegal_fix");

        // Timeout with a partial frame pending.
        digit_slot(3, 1, SLOT);
        digit_slot(2, 1, SLOT);
        st = cyc;
        apply_slot(4'hF, 8'hFF, 100);
        while (cyc < last_t + TIMEOUT - 1) begin @(posedge clk); #1; end
        check("timeout_before", timeout, 1'b0);
        @(posedge clk);
        #1;
        check("timeout_set", timeout, 1'b1);
        check("timeout_hold", {digit_1, digit_2, digit_3, digit_4, blank}, last_frame);
        while (cyc < st + 100) begin @(posedge clk); #1; end
        digit_slot(1, 2, SLOT);
        check("timeout_drop", timeout, 1'b0);
        digit_slot(0, 2, SLOT);
        check_frames("timeout_mask");
        digit_slot(3, 3, SLOT);
        digit_slot(2, 3, SLOT);
        check_frames("timeout_next");

        // Reset in the middle of a frame.
        digit_slot(3, 5, SLOT);
        digit_slot(2, 5, SLOT);
        digit_slot(1, 5, SLOT);
        do_reset();
        check("midrst_digits", {digit_1, digit_2, digit_3, digit_4, blank}, 20'hFFFFF);
        digit_slot(3, 9, SLOT);
        digit_slot(2, 8, SLOT);
        digit_slot(1, 0, SLOT);
        digit_slot(0, 6, SLOT);
        check_frames("midrst");
        check("midrst_out", {digit_1, digit_2, digit_3, digit_4, blank}, 20'h98060);

        // Randomized scanning with blink slots, multi-anode slots and errors.
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                a = ($urandom_range(0, 1) == 0) ? 4'hF : 4'b0101;
                s = 8'($urandom_range(0, 255));
            end else begin
                a = 4'hF;
                a[$urandom_range(0, 3)] = 1'b0;
                if (r == 1) s = 8'h55;
                else s = {1'($urandom_range(0, 1)), seg_tab[$urandom_range(0, 10)]};
            end
            if ({a, s} == last_applied) s[7] = ~s[7];
            drive_slot(a, s, (r == 0) ? 15 : SLOT);
        end
        check_frames("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
